// File: rtl/pingpong_buf_ctrl_if.sv
// Pixel-in / buffer-control bundle for the display double-buffer controller.
// The slave side is the controller; the master side feeds pixels and observes.
interface pingpong_buf_ctrl_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 4
);
    logic [DATA_W-1:0] PixIn;
    logic              PixValid;
    logic              PixReady;
    logic              WrEnBuf0;
    logic              WrEnBuf1;
    logic [ADDR_W-1:0] WrAddr;
    logic [DATA_W-1:0] WrData;
    logic [ADDR_W-1:0] RdAddr;
    logic              SelBuf0;
    logic              SelBuf1;
    logic              SelBlank;
    logic              Underrun;

    modport master (
        output PixIn, PixValid,
        input  PixReady, WrEnBuf0, WrEnBuf1, WrAddr, WrData,
        input  RdAddr, SelBuf0, SelBuf1, SelBlank, Underrun
    );

    modport slave (
        input  PixIn, PixValid,
        output PixReady, WrEnBuf0, WrEnBuf1, WrAddr, WrData,
        output RdAddr, SelBuf0, SelBuf1, SelBlank, Underrun
    );
endinterface

// File: rtl/pingpong_buf_ctrl.sv
// Ping-pong line buffer controller: steers pixels into two line buffers and
// scans each full buffer once, followed by a fixed blanking gap.
module pingpong_buf_ctrl #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned ADDR_W    = 4,
    parameter int unsigned BLANK_LEN = 4
) (
    input logic                Clk,
    input logic                ResetN,
    pingpong_buf_ctrl_if.slave bus
);
    localparam int unsigned BLANK_W = (BLANK_LEN > 1) ? $clog2(BLANK_LEN) : 1;
    localparam logic [ADDR_W-1:0]  LastAddr  = ADDR_W'(DEPTH - 1);
    localparam logic [BLANK_W-1:0] LastBlank = BLANK_W'(BLANK_LEN - 1);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StActive = 2'd1;
    localparam logic [1:0] StBlank  = 2'd2;

    // Writer state
    logic              wrBuf;
    logic [ADDR_W-1:0] wrCnt;
    logic [1:0]        full;
    logic [1:0]        fullNext;
    logic              pixAccept;
    logic              lineDone;
    logic [DATA_W-1:0] pixData;

    // Reader state
    logic [1:0]         state,    stateNext;
    logic               rdBuf,    rdBufNext;
    logic [ADDR_W-1:0]  rdAddr,   rdAddrNext;
    logic [BLANK_W-1:0] blankCnt, blankCntNext;
    logic               underrun, underrunNext;
    logic               selBuf0,  selBuf1, selBlank;
    logic               scanDone;

    assign pixData      = bus.PixIn;
    assign pixAccept    = bus.PixValid & ~full[wrBuf];
    assign lineDone     = pixAccept && (wrCnt == LastAddr);
    assign scanDone     = (state == StActive) && (rdAddr == LastAddr);

    assign bus.PixReady = ~full[wrBuf];
    assign bus.WrData   = pixData;
    assign bus.WrAddr   = wrCnt;
    assign bus.WrEnBuf0 = pixAccept & ~wrBuf;
    assign bus.WrEnBuf1 = pixAccept & wrBuf;
    assign bus.RdAddr   = rdAddr;
    assign bus.SelBuf0  = selBuf0;
    assign bus.SelBuf1  = selBuf1;
    assign bus.SelBlank = selBlank;
    assign bus.Underrun = underrun;

    // A buffer is only set while empty and only cleared while full, so the two
    // updates never target the same bit in one cycle.
    always_comb begin
        fullNext = full;
        if (lineDone) fullNext[wrBuf] = 1'b1;
        if (scanDone) fullNext[rdBuf] = 1'b0;
    end

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            wrBuf <= 1'b0;
            wrCnt <= '0;
            full  <= '0;
        end else begin
            full <= fullNext;
            if (pixAccept) begin
                if (lineDone) begin
                    wrCnt <= '0;
                    wrBuf <= ~wrBuf;
                end else begin
                    wrCnt <= wrCnt + ADDR_W'(1);
                end
            end
        end
    end

    always_comb begin
        stateNext    = state;
        rdBufNext    = rdBuf;
        rdAddrNext   = rdAddr;
        blankCntNext = blankCnt;
        underrunNext = 1'b0;
        unique case (state)
            StIdle: begin
                if (full[rdBuf]) begin
                    stateNext  = StActive;
                    rdAddrNext = '0;
                end
            end
            StActive: begin
                if (rdAddr == LastAddr) begin
                    rdAddrNext   = '0;
                    rdBufNext    = ~rdBuf;
                    blankCntNext = '0;
                    stateNext    = StBlank;
                end else begin
                    rdAddrNext = rdAddr + ADDR_W'(1);
                end
            end
            StBlank: begin
                // rdBuf already points at the next buffer in line here.
                if (blankCnt == LastBlank) begin
                    if (full[rdBuf]) begin
                        stateNext  = StActive;
                        rdAddrNext = '0;
                    end else begin
                        stateNext    = StIdle;
                        underrunNext = 1'b1;
                    end
                end else begin
                    blankCntNext = blankCnt + BLANK_W'(1);
                end
            end
            default: stateNext = StIdle;
        endcase
    end

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            state    <= StIdle;
            rdBuf    <= 1'b0;
            rdAddr   <= '0;
            blankCnt <= '0;
            underrun <= 1'b0;
            selBuf0  <= 1'b0;
            selBuf1  <= 1'b0;
            selBlank <= 1'b1;
        end else begin
            state    <= stateNext;
            rdBuf    <= rdBufNext;
            rdAddr   <= rdAddrNext;
            blankCnt <= blankCntNext;
            underrun <= underrunNext;
            selBuf0  <= (stateNext == StActive) & ~rdBufNext;
            selBuf1  <= (stateNext == StActive) & rdBufNext;
            selBlank <= (stateNext != StActive);
        end
    end
endmodule

// File: tb/tb_pingpong_buf_ctrl.sv
// Scoreboard bench for pingpong_buf_ctrl: a timeline model predicts every
// cycle's reader outputs and every accepted write; a monitor pops and compares.
module tb_pingpong_buf_ctrl;
    localparam int DATA_W    = 8;
    localparam int DEPTH     = 16;
    localparam int ADDR_W    = 4;
    localparam int BLANK_LEN = 4;

    typedef struct packed {
        logic              sel0;
        logic              sel1;
        logic              blank;
        logic              under;
        logic              ready;
        logic [ADDR_W-1:0] rdAddr;
    } rdExpT;

    typedef struct packed {
        logic              bufSel;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wrExpT;

    logic Clk = 1'b0;
    logic ResetN = 1'b1;
    always #5 Clk = ~Clk;

    pingpong_buf_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    pingpong_buf_ctrl #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .ADDR_W   (ADDR_W),
        .BLANK_LEN(BLANK_LEN)
    ) dut (
        .Clk   (Clk),
        .ResetN(ResetN),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;
    rdExpT readQ[$];
    wrExpT writeQ[$];

    // Reference model: reader position on a per-line timeline.
    // -1 idle, 0..DEPTH-1 scanning, DEPTH..DEPTH+BLANK_LEN-1 blanking.
    int       rdPos;
    bit       mRdBuf, mWrBuf, mUnder;
    bit [1:0] mFull;
    int       mWrCnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        rdPos  = -1;
        mRdBuf = 0;
        mWrBuf = 0;
        mUnder = 0;
        mFull  = 2'b00;
        mWrCnt = 0;
    endtask

    task automatic modelStep(input bit acc);
        bit [1:0] f;
        f      = mFull;
        mUnder = 0;
        if (rdPos < 0) begin
            if (mFull[mRdBuf]) rdPos = 0;
        end else if (rdPos < DEPTH - 1) begin
            rdPos++;
        end else if (rdPos == DEPTH - 1) begin
            f[mRdBuf] = 0;
            mRdBuf    = !mRdBuf;
            rdPos++;
        end else if (rdPos < DEPTH + BLANK_LEN - 1) begin
            rdPos++;
        end else if (mFull[mRdBuf]) begin
            rdPos = 0;
        end else begin
            rdPos  = -1;
            mUnder = 1;
        end
        if (acc) begin
            if (mWrCnt == DEPTH - 1) begin
                f[mWrBuf] = 1;
                mWrBuf    = !mWrBuf;
                mWrCnt    = 0;
            end else begin
                mWrCnt++;
            end
        end
        mFull = f;
    endtask

    // Entered at a falling edge, returns at the next falling edge.
    task automatic cycle(input bit valid, input logic [DATA_W-1:0] data);
        rdExpT e;
        wrExpT w;
        bit    scanning;
        bit    ready;
        bus.PixValid = valid;
        bus.PixIn    = data;
        ready        = !mFull[mWrBuf];
        scanning     = (rdPos >= 0) && (rdPos < DEPTH);
        e.sel0   = scanning && !mRdBuf;
        e.sel1   = scanning && mRdBuf;
        e.blank  = !scanning;
        e.under  = mUnder;
        e.ready  = ready;
        e.rdAddr = scanning ? ADDR_W'(rdPos) : '0;
        readQ.push_back(e);
        if (valid && ready) begin
            w.bufSel = mWrBuf;
            w.addr   = ADDR_W'(mWrCnt);
            w.data   = data;
            writeQ.push_back(w);
        end
        @(posedge Clk);
        modelStep(valid && ready);
        @(negedge Clk);
    endtask

    task automatic checkResetValues();
        check("rst_selblank", bus.SelBlank, 1);
        check("rst_sel0", bus.SelBuf0, 0);
        check("rst_sel1", bus.SelBuf1, 0);
        check("rst_rdaddr", bus.RdAddr, 0);
        check("rst_underrun", bus.Underrun, 0);
        check("rst_pixready", bus.PixReady, 1);
        check("rst_onehot", bus.SelBuf0 + bus.SelBuf1 + bus.SelBlank, 1);
    endtask

    // Asynchronous reset asserted mid-cycle, away from either clock edge.
    task automatic doReset();
        bus.PixValid = 1'b0;
        #3 ResetN = 1'b0;
        #1 checkResetValues();
        modelReset();
        @(negedge Clk);
        #3 ResetN = 1'b1;
        @(negedge Clk);
    endtask

    // Monitor: compares whatever the DUT presents against the scoreboard.
    initial begin
        rdExpT e;
        wrExpT w;
        forever begin
            @(negedge Clk);
            #2;
            check("onehot", bus.SelBuf0 + bus.SelBuf1 + bus.SelBlank, 1);
            if (readQ.size() > 0) begin
                e = readQ.pop_front();
                check("pixready", bus.PixReady, e.ready);
                check("selbuf0", bus.SelBuf0, e.sel0);
                check("selbuf1", bus.SelBuf1, e.sel1);
                check("selblank", bus.SelBlank, e.blank);
                check("underrun", bus.Underrun, e.under);
                if (e.sel0 || e.sel1) check("rdaddr", bus.RdAddr, e.rdAddr);
            end
            if (bus.WrEnBuf0 && bus.WrEnBuf1) check("wren_both", 1, 0);
            if (bus.WrEnBuf0 || bus.WrEnBuf1) begin
                if (writeQ.size() == 0) begin
                    check("wr_unexpected", 1, 0);
                end else begin
                    w = writeQ.pop_front();
                    check("wr_buf", bus.WrEnBuf1, w.bufSel);
                    check("wr_addr", bus.WrAddr, w.addr);
                    check("wr_data", bus.WrData, w.data);
                end
            end
        end
    end

    initial begin
        bus.PixValid = 1'b0;
        bus.PixIn    = '0;
        modelReset();
        #1 ResetN = 1'b0;
        #1 checkResetValues();
        @(negedge Clk);
        #3 ResetN = 1'b1;
        @(negedge Clk);

        // One line then silence: scan, blank, single underrun, idle.
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, DATA_W'(i));
        repeat (45) cycle(1'b0, '0);

        // Continuous input: writer stalls on full buffers, readout never starves.
        repeat (200) cycle(1'b1, DATA_W'($urandom));
        repeat (70) cycle(1'b0, '0);

        // Bursty random input.
        repeat (400) cycle($urandom_range(0, 3) != 0, DATA_W'($urandom));
        repeat (60) cycle(1'b0, '0);

        // Reset in the middle of a scan with a partial second line.
        doReset();
        for (int k = 0; k < 100 && rdPos != 7; k++) begin
            cycle((mWrBuf == 0) || (mWrCnt < 9), DATA_W'($urandom));
        end
        if (rdPos != 7) begin
            total++;
            bad++;
            $display("FAIL reset_point: got rdPos %0d want 7", rdPos);
        end
        doReset();

        // First line after reset lands in buffer 0 from address 0.
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, DATA_W'(8'hA0 + i));
        repeat (45) cycle(1'b0, '0);

        #3;
        check("wr_queue_left", writeQ.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
